// File: rtl/comparator_pkg.sv
// Shared types and helpers for comparator_scheduler.
//   state_e  : scheduler FSM states
//   OPW      : operand width (fixed at 2 bits)
//   MAX_REQ  : largest supported requester count
//   rr_pick  : round-robin grant search starting at a pointer
package comparator_pkg;

    localparam int unsigned OPW     = 2;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

    // First index with valid set, searching upward from ptr and wrapping modulo nreq.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int unsigned        nreq);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                idx = (32'(ptr) + k) % nreq;
                if (!found && valid[3'(idx)]) begin
                    pick  = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/comparator_scheduler_if.sv
// Request/response bus of comparator_scheduler.
//   req_valid/req_x/req_y/req_ready : per-requester operand handshake (2 bits per requester)
//   rsp_valid/rsp_ready/rsp_id/rsp_eq : tagged equality result handshake
// master: requester/consumer side; slave: the scheduler.
interface comparator_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    import comparator_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [OPW*NREQ-1:0] req_x;
    logic [OPW*NREQ-1:0] req_y;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_eq;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_eq
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_eq
    );

endinterface

// File: rtl/comparatore_4in.sv
// Combinational 2-bit equality core: out = 1 when {a,b} == {c,d}.
//   a, b : operand x (msb, lsb)
//   c, d : operand y (msb, lsb)
//   out  : equality result
module comparatore_4in (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out
);

    assign out = (a ~^ c) & (b ~^ d);

endmodule

// File: rtl/comparator_scheduler.sv
// Round-robin scheduler sharing one 2-bit equality core between NREQ requesters.
//   clk, rst_n          : clock and asynchronous active-low reset
//   bus (slave)         : request handshake in, tagged result handshake out
//   stat_clr            : synchronous clear of both statistics counters
//   busy                : high whenever the FSM is not idle
//   cmp_count, eq_count : saturating counts of completed and equal compares
module comparator_scheduler
    import comparator_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    comparator_scheduler_if.slave   bus,
    input  logic                    stat_clr,
    output logic                    busy,
    output logic [CNT_W-1:0]        cmp_count,
    output logic [CNT_W-1:0]        eq_count
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [OPW-1:0]     x_q, x_d;
    logic [OPW-1:0]     y_q, y_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_eq_q, rsp_eq_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]   eq_q, eq_d;

    logic [MAX_REQ-1:0] valid_ext;
    logic               any_valid;
    logic [ID_W-1:0]    grant;
    logic [NREQ-1:0]    grant_oh;
    logic [OPW-1:0]     sel_x;
    logic [OPW-1:0]     sel_y;
    logic               core_eq;
    logic               rsp_hs;

    // Grant selection and operand mux; constant-index loops keep every select in range.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = bus.req_valid;
        any_valid             = |bus.req_valid;
        grant                 = ID_W'(rr_pick(valid_ext, 3'(rr_ptr_q), NREQ));
        grant_oh              = '0;
        sel_x                 = '0;
        sel_y                 = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant == ID_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_x       = bus.req_x[i*OPW +: OPW];
                sel_y       = bus.req_y[i*OPW +: OPW];
            end
        end
    end

    comparatore_4in u_core (
        .a   (x_q[1]),
        .b   (x_q[0]),
        .c   (y_q[1]),
        .d   (y_q[0]),
        .out (core_eq)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gid_d         = gid_q;
        x_d           = x_q;
        y_d           = y_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_eq_d      = rsp_eq_q;
        bus.req_ready = '0;
        rsp_hs        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    bus.req_ready = grant_oh;
                    x_d           = sel_x;
                    y_d           = sel_y;
                    gid_d         = grant;
                    state_d       = StCmp;
                end
            end
            StCmp: begin
                rsp_eq_d    = core_eq;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_hs      = 1'b1;
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + ID_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating statistics; a clear beats a coincident increment.
    always_comb begin
        cmp_d = cmp_q;
        eq_d  = eq_q;
        if (stat_clr) begin
            cmp_d = '0;
            eq_d  = '0;
        end else if (rsp_hs) begin
            if (cmp_q != '1) cmp_d = cmp_q + CNT_W'(1);
            if (rsp_eq_q && (eq_q != '1)) eq_d = eq_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gid_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_eq_q    <= 1'b0;
            cmp_q       <= '0;
            eq_q        <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gid_q       <= gid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_eq_q    <= rsp_eq_d;
            cmp_q       <= cmp_d;
            eq_q        <= eq_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_eq    = rsp_eq_q;
    assign busy          = (state_q != StIdle);
    assign cmp_count     = cmp_q;
    assign eq_count      = eq_q;

endmodule

// File: doc/comparator_scheduler.md
Name: comparator_scheduler

Overview:
- Round-robin scheduler that shares one combinational 2-bit equality core between NREQ requesters.
- Each requester offers an operand pair (x, y) over a valid/ready handshake. The block grants one requester, registers its operands into the core, and returns the equality result tagged with the requester id.
- Keeps saturating statistics counters for total compares and equal results.
- Sits between requester logic and the comparator datapath; it owns all sequencing of the core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal clog2(NREQ).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  2*NREQ  operand x; requester i uses bits [2i+1:2i].
- req_y  in  2*NREQ  operand y; same packing as req_x.
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  id of the requester that produced the result.
- rsp_eq  out  1  1 when x == y.
- busy  out  1  high in any state other than IDLE.
- stat_clr  in  1  synchronous clear of both counters.
- cmp_count  out  CNT_W  number of completed compares.
- eq_count  out  CNT_W  number of completed compares with rsp_eq = 1.

Behaviour:
- Reset (asynchronous, rst_n = 0) values:
  - FSM = IDLE; rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_eq = 0, busy = 0.
  - cmp_count = 0, eq_count = 0.
  - Operand registers = 0.
- Reset mid-operation aborts the transaction. No response is produced and the request is lost; requesters must re-present it.
- Requester rule: hold req_valid, req_x and req_y stable until req_ready[i] = 1. Dropping valid before acceptance is legal and withdraws the request.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i] = 1, searching upward from rr_ptr with wrap modulo NREQ.
  - req_ready[g] = 1 combinationally in that cycle; all other bits are 0.
  - On the clock edge: latch req_x[g], req_y[g] and g; go to CMP.
  - If no request is valid, stay in IDLE and keep req_ready = 0.
- CMP:
  - Latched operands drive the core.
  - On the edge: register the core output into rsp_eq and g into rsp_id; set rsp_valid = 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_eq stable.
  - On rsp_valid && rsp_ready: clear rsp_valid, set rr_ptr = (g + 1) mod NREQ, increment the counters, return to IDLE.
  - No new acceptance is possible before the next IDLE cycle.
- Latency and throughput:
  - Accept in cycle T gives rsp_valid in cycle T+2.
  - Maximum throughput is 1 result per 3 cycles when rsp_ready is held at 1.
- Backpressure: rsp_ready = 0 stalls in RESP indefinitely. req_ready stays 0 for the whole stall.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,... Any continuously valid requester is granted within NREQ transactions.
- Counters:
  - cmp_count increments by 1 on each response handshake.
  - eq_count increments by 1 only when rsp_eq = 1 at that handshake.
  - Both saturate at all-ones and never wrap.
  - stat_clr = 1 clears both counters to 0 at the next edge. Clear wins over a simultaneous increment.
- Operand width is fixed at 2 bits. The equality core compares {a,b} against {c,d}.

Decomposition:
- Package comparator_pkg:
  - FSM state enum (IDLE, CMP, RESP).
  - OPW = 2 operand width constant.
  - Function rr_pick(valid, ptr) returning the granted index.
- Sub-module: reuse comparatore_4in, the existing combinational core (a, b, c, d to out).
  - Connect a = x[1], b = x[0], c = y[1], d = y[0].
  - out = 1 when x == y.
- Arbiter, FSM and counters stay in the top level.

Test Plan:
- Reset then single request: req_valid = 4'b0001, x = 2'b10, y = 2'b10, rsp_ready = 1.
  - Expect req_ready = 4'b0001 in cycle T, then rsp_valid at T+2 with rsp_id = 0, rsp_eq = 1.
  - Expect cmp_count = 1, eq_count = 1.
- Mismatch: requester 2 with x = 2'b01, y = 2'b11.
  - Expect rsp_id = 2, rsp_eq = 0; cmp_count increments, eq_count does not.
- Fairness: all four valid continuously with rsp_ready = 1.
  - Expect grant order 0,1,2,3,0 and responses spaced exactly 3 cycles apart.
- Backpressure: rsp_ready = 0 for 10 cycles after a response is raised.
  - Expect rsp_valid, rsp_id and rsp_eq held stable, req_ready = 0 throughout, busy = 1.
  - Release rsp_ready: completes in 1 cycle.
- Reset mid-op: assert rst_n = 0 while in CMP.
  - Expect all outputs 0 immediately, no response after release, next grant starts at requester 0.
- Counters:
  - Preload-by-traffic to all-ones (use CNT_W = 4): after 15 equal compares, a 16th keeps both counters at 4'hF.
  - stat_clr coincident with a handshake yields 0.
